split_merge_task_seq: RTL and testbench
=======================================

SPLIT_MERGE_TASK_SEQ -- requirements
Module: split_merge_task_seq

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: descriptor queue depth, power of two, at least 2.
REQ-002 Parameter TIMEOUT_CYC, default 1024: maximum cycles to wait for op_done per task.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 desc_valid  in  1  descriptor offered.
REQ-006 desc_ready  out  1  descriptor accepted when desc_valid and desc_ready are both high.
REQ-007 desc  in  sm_desc_t  fields: task_type [2:0], stage [4:0], in_pos, out_pos, base_addr[3] (mem_addr_t each).
REQ-008 abort  in  1  flush queue, drop in-flight wait, return to IDLE.
REQ-009 task_start  out  1  one-cycle start pulse to the split/merge operator.
REQ-010 input_task  out  TASK_REDUCE_BW  packed task word to the operator.
REQ-011 op_done  in  1  operator completion pulse.
REQ-012 busy  out  1  high when not IDLE or queue non-empty.
REQ-013 done_cnt  out  16  count of tasks completed by op_done, wrapping.
REQ-014 err_illegal  out  1  one-cycle pulse when a popped descriptor is rejected.
REQ-015 err_timeout  out  1  sticky timeout flag.
REQ-016 err_spurious  out  1  sticky flag for op_done seen outside WAIT.

Function
REQ-017 desc_ready shall equal queue-not-full; a push while full shall be impossible.
REQ-018 FSM states: IDLE, CHECK, ISSUE, WAIT, ERR.
REQ-019 IDLE: if queue non-empty, pop the head into a holding register and go to CHECK.
REQ-020 CHECK (1 cycle): legal = task_type in {2,3,4,5} and stage<=8 and (stage!=8 or task_type in {4,5}); if legal go to ISSUE, else pulse err_illegal and go to IDLE.
REQ-021 ISSUE: register input_task, pulse task_start for exactly one cycle, clear the timeout counter, go to WAIT.
REQ-022 input_task packing: [4]=in_pos, [5]=out_pos, [7:6]=0 (FFT mode), [10:8]=task_type, [15:11]=stage; base_addr[k] is placed at [TASK_REDUCE_BW-k*MEM_ADDR_BITS-1 : TASK_REDUCE_BW-(k+1)*MEM_ADDR_BITS] for k=0..2; all other bits are 0.
REQ-023 input_task shall be stable from the task_start cycle until the cycle after op_done.
REQ-024 WAIT: op_done increments done_cnt and returns to IDLE; the next task_start occurs no earlier than 3 cycles after op_done.
REQ-025 WAIT: the counter increments each cycle; on reaching TIMEOUT_CYC without op_done, set err_timeout and go to ERR.
REQ-026 ERR: hold and accept no pops; desc_ready still follows queue fullness; only abort or rst exits ERR.
REQ-027 abort in any state: empty the queue, go to IDLE next cycle, clear err_timeout and err_spurious, keep done_cnt; a push in the abort cycle shall be discarded.
REQ-028 An op_done in any state other than WAIT shall set err_spurious and change nothing else.
REQ-029 Simultaneous push and pop on the same cycle shall be allowed, including when the queue is full.
REQ-030 Minimum latency from accepting a descriptor into an empty queue while IDLE to task_start shall be 3 cycles.

Reset
REQ-031 On rst: queue empty, FSM in IDLE, task_start=0, input_task=0, busy=0, done_cnt=0, all error flags 0, desc_ready=1.
REQ-032 A reset asserted mid-WAIT shall drop the task and produce no err_* or done_cnt update.

Structure
REQ-033 The shared package shall hold sm_desc_t, the task-type codes (SPLIT_256=2, MERGE_256=3, SPLIT_512=4, MERGE_512=5), the input_task bit-offset constants, and the FSM state enum; mem_addr_t, MEM_ADDR_BITS and TASK_REDUCE_BW are taken from the existing package.
REQ-034 The queue shall be one sub-module, sm_desc_fifo: synchronous, parameterised depth and width, with full/empty flags.

Verification
REQ-035 Push one SPLIT_512 descriptor with stage 5, addresses 0x10/0x20/0x30, in_pos=1; operator responds with op_done 40 cycles after start -> task_start 3 cycles after accept, fields placed per REQ-022, done_cnt=1, busy low 1 cycle after op_done.
REQ-036 Push a MERGE_256 descriptor with stage 8 -> err_illegal pulses once, no task_start, done_cnt unchanged.
REQ-037 Push 5 descriptors back-to-back with FIFO_DEPTH=4 and op_done delayed -> desc_ready drops after 4 pending descriptors; all 5 are issued in order; done_cnt=5.
REQ-038 Never assert op_done with TIMEOUT_CYC=16 -> err_timeout set at cycle 16 of WAIT, state ERR, no further starts; then abort -> IDLE, flags cleared.
REQ-039 op_done pulse while IDLE -> err_spurious=1, done_cnt unchanged.
REQ-040 Assert rst during WAIT with 2 descriptors queued -> all outputs at reset values; no task_start after release until a new push.

Source files
------------

// File: rtl/split_merge_task_seq_pkg.sv
// Shared types for the split/merge task sequencer: descriptor, task codes,
// input_task bit layout and FSM states.
package split_merge_task_seq_pkg;

  // Memory address and task word widths as seen by the split/merge operator.
  localparam int MEM_ADDR_BITS  = 12;
  localparam int TASK_REDUCE_BW = 64;
  typedef logic [MEM_ADDR_BITS-1:0] mem_addr_t;

  localparam logic [2:0] SPLIT_256 = 3'd2;
  localparam logic [2:0] MERGE_256 = 3'd3;
  localparam logic [2:0] SPLIT_512 = 3'd4;
  localparam logic [2:0] MERGE_512 = 3'd5;

  localparam logic [4:0] MAX_STAGE = 5'd8;
  localparam logic [1:0] MODE_FFT  = 2'd0;

  localparam int IT_IN_POS    = 4;
  localparam int IT_OUT_POS   = 5;
  localparam int IT_MODE_LSB  = 6;
  localparam int IT_TYPE_LSB  = 8;
  localparam int IT_STAGE_LSB = 11;

  typedef struct packed {
    logic [2:0]      task_type;
    logic [4:0]      stage;
    logic            in_pos;
    logic            out_pos;
    mem_addr_t [2:0] base_addr;
  } sm_desc_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_ISSUE,
    ST_WAIT,
    ST_ERR
  } sm_state_t;

  // The last stage only exists for the 512-point variants.
  function automatic logic desc_legal(sm_desc_t d);
    logic big;
    big = (d.task_type == SPLIT_512) || (d.task_type == MERGE_512);
    return (d.task_type inside {SPLIT_256, MERGE_256, SPLIT_512, MERGE_512}) &&
           (d.stage <= MAX_STAGE) && ((d.stage != MAX_STAGE) || big);
  endfunction

  // Base addresses are stacked downward from the top of the word.
  function automatic logic [TASK_REDUCE_BW-1:0] pack_task(sm_desc_t d);
    logic [TASK_REDUCE_BW-1:0] w;
    w = '0;
    w[IT_IN_POS]              = d.in_pos;
    w[IT_OUT_POS]             = d.out_pos;
    w[IT_MODE_LSB +: 2]       = MODE_FFT;
    w[IT_TYPE_LSB +: 3]       = d.task_type;
    w[IT_STAGE_LSB +: 5]      = d.stage;
    for (int k = 0; k < 3; k++) begin
      w[TASK_REDUCE_BW-(k+1)*MEM_ADDR_BITS +: MEM_ADDR_BITS] = d.base_addr[k];
    end
    return w;
  endfunction

endpackage

// File: rtl/split_merge_task_seq_fifo.sv
// Descriptor queue: synchronous FIFO, head visible combinationally, pop takes effect at the edge.
// Push while full is accepted only together with a pop; flush wins over push and pop.
module sm_desc_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/split_merge_task_seq.sv
// Queues split/merge descriptors, validates them and issues one task at a time to the operator.
// Accept-to-start latency 3 cycles; desc_ready follows queue space; abort flushes everything.
module split_merge_task_seq
  import split_merge_task_seq_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      desc_valid,
  output logic                      desc_ready,
  input  sm_desc_t                  desc,
  input  logic                      abort,
  output logic                      task_start,
  output logic [TASK_REDUCE_BW-1:0] input_task,
  input  logic                      op_done,
  output logic                      busy,
  output logic [15:0]               done_cnt,
  output logic                      err_illegal,
  output logic                      err_timeout,
  output logic                      err_spurious
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  sm_state_t       state;
  sm_desc_t        hold;
  sm_desc_t        fifo_head;
  logic            fifo_full;
  logic            fifo_empty;
  logic            fifo_push;
  logic            fifo_pop;
  logic [TW-1:0]   tmo_cnt;

  assign desc_ready = !fifo_full;
  assign fifo_push  = desc_valid && desc_ready;
  assign fifo_pop   = (state == ST_IDLE) && !fifo_empty && !abort;
  assign busy       = (state != ST_IDLE) || !fifo_empty;

  sm_desc_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(sm_desc_t))
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (abort),
    .push      (fifo_push),
    .push_data (desc),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      hold         <= '0;
      input_task   <= '0;
      task_start   <= 1'b0;
      tmo_cnt      <= '0;
      done_cnt     <= '0;
      err_illegal  <= 1'b0;
      err_timeout  <= 1'b0;
      err_spurious <= 1'b0;
    end else begin
      task_start  <= 1'b0;
      err_illegal <= 1'b0;
      if (abort) begin
        state        <= ST_IDLE;
        tmo_cnt      <= '0;
        err_timeout  <= 1'b0;
        err_spurious <= 1'b0;
      end else begin
        if (op_done && (state != ST_WAIT)) err_spurious <= 1'b1;
        case (state)
          ST_IDLE: begin
            if (!fifo_empty) begin
              hold  <= fifo_head;
              state <= ST_CHECK;
            end
          end
          ST_CHECK: begin
            if (desc_legal(hold)) begin
              state <= ST_ISSUE;
            end else begin
              err_illegal <= 1'b1;
              state       <= ST_IDLE;
            end
          end
          ST_ISSUE: begin
            input_task <= pack_task(hold);
            task_start <= 1'b1;
            tmo_cnt    <= '0;
            state      <= ST_WAIT;
          end
          ST_WAIT: begin
            // Completion wins over a timeout expiring in the same cycle.
            if (op_done) begin
              done_cnt <= done_cnt + 16'd1;
              state    <= ST_IDLE;
            end else if (tmo_cnt == TW'(TIMEOUT_CYC - 1)) begin
              err_timeout <= 1'b1;
              state       <= ST_ERR;
            end else begin
              tmo_cnt <= tmo_cnt + 1'b1;
            end
          end
          ST_ERR:  state <= ST_ERR;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_split_merge_task_seq.sv
// Scoreboard bench: expected task words queued at push, checked by a monitor on task_start.
module tb_split_merge_task_seq;
  import split_merge_task_seq_pkg::*;

  localparam int TMO = 48;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      desc_valid;
  logic                      desc_ready;
  sm_desc_t                  desc;
  logic                      abort;
  logic                      task_start;
  logic [TASK_REDUCE_BW-1:0] input_task;
  logic                      op_done;
  logic                      busy;
  logic [15:0]               done_cnt;
  logic                      err_illegal;
  logic                      err_timeout;
  logic                      err_spurious;
  logic                      resp_done = 1'b0;
  logic                      man_done  = 1'b0;

  int checks = 0, errors = 0, cyc = 0;
  int start_cnt = 0, start_cyc = 0, illegal_cnt = 0;
  int op_delay = 0, cd = 0;
  logic [63:0] exp_q[$];

  assign op_done = resp_done | man_done;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  split_merge_task_seq #(.FIFO_DEPTH(4), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .desc_valid(desc_valid), .desc_ready(desc_ready), .desc(desc),
    .abort(abort), .task_start(task_start), .input_task(input_task), .op_done(op_done),
    .busy(busy), .done_cnt(done_cnt), .err_illegal(err_illegal),
    .err_timeout(err_timeout), .err_spurious(err_spurious)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every task_start must match the oldest expected task word.
  always @(negedge clk) begin
    if (err_illegal) illegal_cnt++;
    if (task_start) begin
      start_cnt++;
      start_cyc = cyc;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_start: got %0h expected no start", input_task);
      end else begin
        check("input_task", input_task, exp_q.pop_front());
      end
    end
  end

  // Operator model: op_done is sampled op_delay cycles after task_start (0 = never).
  always @(negedge clk) begin
    resp_done = 1'b0;
    if (cd > 0) begin
      cd--;
      if (cd == 0) resp_done = 1'b1;
    end
    if (task_start && op_delay > 1) cd = op_delay - 1;
  end

  function automatic sm_desc_t mk(logic [2:0] t, logic [4:0] s, logic ip, logic op,
                                  mem_addr_t a0, mem_addr_t a1, mem_addr_t a2);
    sm_desc_t d;
    d.task_type    = t;
    d.stage        = s;
    d.in_pos       = ip;
    d.out_pos      = op;
    d.base_addr[0] = a0;
    d.base_addr[1] = a1;
    d.base_addr[2] = a2;
    return d;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic push(input sm_desc_t d, input bit expect_start, input logic [63:0] exp,
                      output int acc);
    int n = 0;
    desc       = d;
    desc_valid = 1'b1;
    while (!desc_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("push_accept", 64'(desc_ready), 64'd1);
    @(posedge clk);
    if (expect_start) exp_q.push_back(exp);
    #1;
    acc        = cyc;
    desc_valid = 1'b0;
  endtask

  task automatic wait_idle(input int maxc);
    int n = 0;
    @(negedge clk);
    while (busy && n < maxc) begin
      @(negedge clk);
      n++;
    end
    check("idle_reached", 64'(busy), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_desc_ready"}, 64'(desc_ready), 64'd1);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_task_start"}, 64'(task_start), 64'd0);
    check({tag, "_input_task"}, input_task, 64'd0);
    check({tag, "_done_cnt"}, 64'(done_cnt), 64'd0);
    check({tag, "_err_illegal"}, 64'(err_illegal), 64'd0);
    check({tag, "_err_timeout"}, 64'(err_timeout), 64'd0);
    check({tag, "_err_spurious"}, 64'(err_spurious), 64'd0);
  endtask

  initial begin
    int acc, s0, i0, n;
    sm_desc_t da, db, dc, dd, de;
    rst = 1'b1; desc_valid = 1'b0; abort = 1'b0; desc = '0;
    da = mk(SPLIT_256, 5'd0, 1'b0, 1'b0, 12'h000, 12'h000, 12'h000);
    db = mk(MERGE_256, 5'd7, 1'b1, 1'b1, 12'h001, 12'h002, 12'h003);
    dc = mk(MERGE_512, 5'd8, 1'b0, 1'b1, 12'hABC, 12'h123, 12'hFFF);
    dd = mk(SPLIT_512, 5'd5, 1'b1, 1'b0, 12'h010, 12'h020, 12'h030);
    de = mk(SPLIT_256, 5'd0, 1'b1, 1'b0, 12'hFFF, 12'h000, 12'h555);
    tick(3);
    check_reset_outputs("rst");
    rst = 1'b0;
    tick(2);

    // Single SPLIT_512 task, op_done 40 cycles after start.
    op_delay = 40;
    push(dd, 1'b1, 64'h0100_2003_0000_2C10, acc);
    wait_idle(200);
    check("start_latency", 64'(start_cyc - acc), 64'd3);
    check("done_after_start", 64'(cyc - start_cyc), 64'd40);
    check("done_cnt_1", 64'(done_cnt), 64'd1);
    check("task_stable", input_task, 64'h0100_2003_0000_2C10);

    // Illegal descriptors: none issue, one err_illegal pulse each.
    i0 = illegal_cnt; s0 = start_cnt;
    push(mk(MERGE_256, 5'd8, 1'b0, 1'b0, 12'h1, 12'h2, 12'h3), 1'b0, 64'd0, acc);
    tick(6);
    check("illegal_one", 64'(illegal_cnt - i0), 64'd1);
    push(mk(3'd0, 5'd0, 1'b0, 1'b0, 12'h0, 12'h0, 12'h0), 1'b0, 64'd0, acc);
    push(mk(3'd6, 5'd1, 1'b0, 1'b0, 12'h0, 12'h0, 12'h0), 1'b0, 64'd0, acc);
    push(mk(SPLIT_512, 5'd9, 1'b0, 1'b0, 12'h0, 12'h0, 12'h0), 1'b0, 64'd0, acc);
    push(mk(SPLIT_256, 5'd8, 1'b0, 1'b0, 12'h0, 12'h0, 12'h0), 1'b0, 64'd0, acc);
    tick(20);
    check("illegal_total", 64'(illegal_cnt - i0), 64'd5);
    check("illegal_no_start", 64'(start_cnt - s0), 64'd0);
    check("illegal_done_cnt", 64'(done_cnt), 64'd1);

    // Five back-to-back pushes into a depth-4 queue.
    op_delay = 20;
    s0 = start_cnt;
    push(da, 1'b1, 64'h0000_0000_0000_0200, acc);
    push(db, 1'b1, 64'h0010_0200_3000_3B30, acc);
    push(dc, 1'b1, 64'hABC1_23FF_F000_4520, acc);
    push(dd, 1'b1, 64'h0100_2003_0000_2C10, acc);
    push(de, 1'b1, 64'hFFF0_0055_5000_0210, acc);
    check("ready_full", 64'(desc_ready), 64'd0);
    wait_idle(600);
    check("burst_starts", 64'(start_cnt - s0), 64'd5);
    check("burst_done_cnt", 64'(done_cnt), 64'd6);
    check("burst_queue_drained", 64'(exp_q.size()), 64'd0);

    // Timeout: no op_done, error after TMO cycles of WAIT, then abort.
    op_delay = 0;
    push(da, 1'b1, 64'h0000_0000_0000_0200, acc);
    n = 0;
    @(negedge clk);
    while (!err_timeout && n < 300) begin
      @(negedge clk);
      n++;
    end
    #1;
    check("timeout_cycle", 64'(cyc - start_cyc), 64'(TMO));
    check("err_busy", 64'(busy), 64'd1);
    s0 = start_cnt;
    push(db, 1'b0, 64'd0, acc);
    tick(10);
    check("err_no_start", 64'(start_cnt - s0), 64'd0);
    check("err_ready", 64'(desc_ready), 64'd1);
    abort = 1'b1; desc = dc; desc_valid = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0; desc_valid = 1'b0;
    check("abort_timeout_clr", 64'(err_timeout), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    tick(10);
    check("abort_no_start", 64'(start_cnt - s0), 64'd0);
    check("abort_done_kept", 64'(done_cnt), 64'd6);

    // Spurious op_done while idle.
    man_done = 1'b1;
    @(posedge clk);
    #1;
    man_done = 1'b0;
    tick(2);
    check("spurious_set", 64'(err_spurious), 64'd1);
    check("spurious_done_cnt", 64'(done_cnt), 64'd6);
    check("spurious_busy", 64'(busy), 64'd0);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    check("spurious_clr", 64'(err_spurious), 64'd0);

    // Reset during WAIT with two descriptors still queued.
    op_delay = 0;
    s0 = start_cnt;
    push(da, 1'b1, 64'h0000_0000_0000_0200, acc);
    push(db, 1'b0, 64'd0, acc);
    push(dc, 1'b0, 64'd0, acc);
    tick(5);
    check("wait_started", 64'(start_cnt - s0), 64'd1);
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    tick(2);
    rst = 1'b0;
    tick(10);
    check("post_rst_no_start", 64'(start_cnt - s0), 64'd1);
    check("post_rst_busy", 64'(busy), 64'd0);
    check("post_rst_done_cnt", 64'(done_cnt), 64'd0);
    check("post_rst_errs", 64'({err_illegal, err_timeout, err_spurious}), 64'd0);
    op_delay = 5;
    push(dc, 1'b1, 64'hABC1_23FF_F000_4520, acc);
    wait_idle(100);
    check("post_rst_done", 64'(done_cnt), 64'd1);
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
